// File: rtl/mux_sel_pkg.sv
// Shared definitions for the round-robin mux select arbiter.
package mux_sel_pkg;

    localparam int unsigned N_CH  = 4;
    localparam int unsigned SEL_W = 2;
    localparam int unsigned CNT_W = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_e;

    function automatic logic [N_CH-1:0] onehot(input logic [SEL_W-1:0] idx);
        return N_CH'(1) << idx;
    endfunction

endpackage

// File: rtl/rr_pick_v.sv
// Combinational round-robin picker: first unmasked requester scanning up from ptr with wrap.
module rr_pick_v
    import mux_sel_pkg::*;
(
    input  logic [N_CH-1:0]  req,
    input  logic [SEL_W-1:0] ptr,
    input  logic [N_CH-1:0]  mask,
    output logic [SEL_W-1:0] idx,
    output logic             found
);

    logic [N_CH-1:0] w_eff;

    assign w_eff = req & ~mask;

    always_comb begin
        logic [SEL_W-1:0] cand;
        found = 1'b0;
        idx   = ptr;
        cand  = ptr;
        for (int i = 0; i < N_CH; i++) begin
            cand = ptr + SEL_W'(i);
            if (!found && w_eff[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/mux_sel_arbiter_v.sv
// Round-robin arbiter driving the 4:1 mux select/enable, with a bounded hold per grant
// while other channels are waiting.
module mux_sel_arbiter_v
    import mux_sel_pkg::*;
#(
    parameter int unsigned N_HOLD = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [N_CH-1:0]  i_req,
    input  logic             i_ack,
    output logic [SEL_W-1:0] o_sel_code,
    output logic             o_en,
    output logic [N_CH-1:0]  o_grant
);

    state_e           r_state, w_state_d;
    logic [SEL_W-1:0] r_ptr, w_ptr_d;
    logic [CNT_W-1:0] r_cnt, w_cnt_d;
    logic [SEL_W-1:0] r_owner, w_owner_d;
    logic             r_en, w_en_d;
    logic [N_CH-1:0]  r_grant, w_grant_d;

    logic [CNT_W-1:0] w_cnt_inc;
    logic             w_rel_a, w_rel_b, w_others;
    logic [N_CH-1:0]  w_mask;
    logic [SEL_W-1:0] w_idx;
    logic             w_found;

    assign w_cnt_inc = (r_en && i_ack && (r_cnt != {CNT_W{1'b1}})) ? r_cnt + CNT_W'(1) : r_cnt;
    assign w_others  = |(i_req & ~onehot(r_owner));
    assign w_rel_a   = !i_req[r_owner];
    assign w_rel_b   = (w_cnt_inc >= CNT_W'(N_HOLD)) && w_others;
    // Mask the owner only for a hold-limit release; a dropped owner is not requesting anyway.
    assign w_mask    = (r_state == GRANT && !w_rel_a) ? onehot(r_owner) : '0;

    rr_pick_v u_pick (
        .req   (i_req),
        .ptr   (r_ptr),
        .mask  (w_mask),
        .idx   (w_idx),
        .found (w_found)
    );

    always_comb begin
        w_state_d = r_state;
        w_ptr_d   = r_ptr;
        w_cnt_d   = r_cnt;
        w_owner_d = r_owner;
        w_en_d    = r_en;
        w_grant_d = r_grant;
        unique case (r_state)
            IDLE: begin
                if (w_found) begin
                    w_state_d = GRANT;
                    w_owner_d = w_idx;
                    w_cnt_d   = '0;
                    w_ptr_d   = w_idx + SEL_W'(1);
                    w_en_d    = 1'b1;
                    w_grant_d = onehot(w_idx);
                end
            end
            GRANT: begin
                w_cnt_d = w_cnt_inc;
                if (w_rel_a || w_rel_b) begin
                    if (w_found) begin
                        w_owner_d = w_idx;
                        w_cnt_d   = '0;
                        w_ptr_d   = w_idx + SEL_W'(1);
                        w_grant_d = onehot(w_idx);
                    end else begin
                        w_state_d = IDLE;
                        w_en_d    = 1'b0;
                        w_grant_d = '0;
                    end
                end
            end
            default: w_state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= IDLE;
            r_ptr   <= '0;
            r_cnt   <= '0;
            r_owner <= '0;
            r_en    <= 1'b0;
            r_grant <= '0;
        end else begin
            r_state <= w_state_d;
            r_ptr   <= w_ptr_d;
            r_cnt   <= w_cnt_d;
            r_owner <= w_owner_d;
            r_en    <= w_en_d;
            r_grant <= w_grant_d;
        end
    end

    assign o_sel_code = r_owner;
    assign o_en       = r_en;
    assign o_grant    = r_grant;

endmodule
